wm8731_master_if: RTL and testbench

- Master-mode digital audio interface for the WM8731 codec, with the codec run as audio-interface slave.
- Generates BCLK and LRCK (DACLRC/ADCLRC tied together on board) from the system clock.
- Serializes 16-bit stereo DAC samples and deserializes 16-bit stereo ADC samples, in I2S or DSP mode A.
- Sits between the audio processing datapath and the codec pins; it is the clock-driving counterpart of the existing slave-mode data interface.

---
 rtl/wm8731_pkg.sv | 45 ++++
 rtl/wm8731_bclk_gen.sv | 38 +++
 rtl/wm8731_master_if.sv | 155 +++++++++++++++
 tb/tb_wm8731_master_if.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wm8731_pkg.sv
// Shared constants, types and slot-position decoding for the WM8731 master-mode audio interface.
package wm8731_pkg;

    localparam logic MODE_I2S = 1'b1;
    localparam logic MODE_PCM = 1'b0;
    localparam int   SAMPLE_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic       valid;
        logic       right;
        logic [3:0] idx;
    } slot_pos_t;

    // Maps a frame bit position to the sample bit it carries (if any) for the given mode.
    function automatic slot_pos_t slot_pos(int cnt, int slot_bits, logic mode);
        slot_pos_t pos;
        int        k;
        pos = '0;
        k   = cnt % slot_bits;
        if (mode == MODE_I2S) begin
            if (k >= 1 && k <= SAMPLE_W) begin
                pos.valid = 1'b1;
                pos.right = (cnt >= slot_bits);
                pos.idx   = 4'(SAMPLE_W - k);
            end
        end else begin
            if (cnt >= 1 && cnt <= SAMPLE_W) begin
                pos.valid = 1'b1;
                pos.right = 1'b0;
                pos.idx   = 4'(SAMPLE_W - cnt);
            end else if (cnt > SAMPLE_W && cnt <= 2 * SAMPLE_W) begin
                pos.valid = 1'b1;
                pos.right = 1'b1;
                pos.idx   = 4'(2 * SAMPLE_W - cnt);
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/wm8731_bclk_gen.sv
// BCLK divider: toggles o_bclk every BCLK_HALF cycles while running and flags
// the cycle in which each rising or falling edge is produced.
module wm8731_bclk_gen #(
    parameter int BCLK_HALF = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_run,
    output logic o_bclk,
    output logic o_rise_evt,
    output logic o_fall_evt
);

    logic [7:0] r_div;
    logic       r_bclk;
    logic       w_tc;

    assign w_tc       = i_run && (r_div == 8'(BCLK_HALF - 1));
    assign o_rise_evt = w_tc && !r_bclk;
    assign o_fall_evt = w_tc && r_bclk;
    assign o_bclk     = r_bclk;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (!i_run) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_tc) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div <= r_div + 8'd1;
        end
    end

endmodule

// File: rtl/wm8731_master_if.sv
// WM8731 audio interface in clock-master role: drives BCLK/LRCK, shifts 16-bit
// stereo DAC samples out and collects ADC samples, in I2S or DSP mode A.
module wm8731_master_if
    import wm8731_pkg::*;
#(
    parameter int BCLK_HALF = 8,
    parameter int SLOT_BITS = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_mode,
    input  logic signed [15:0] i_data_left,
    input  logic signed [15:0] i_data_right,
    input  logic               i_adc_dat,
    output logic               o_bclk,
    output logic               o_lrck,
    output logic               o_dac_dat,
    output logic               o_strobe,
    output logic signed [15:0] o_data_left,
    output logic signed [15:0] o_data_right
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);

    state_t                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_mode;
    logic signed [15:0]        r_tx_left;
    logic signed [15:0]        r_tx_right;
    logic signed [15:0]        r_rx_left;
    logic signed [15:0]        r_rx_right;
    logic                      r_adc_meta;
    logic                      r_adc_sync;

    logic                      w_run;
    logic                      w_bclk;
    logic                      w_rise;
    logic                      w_fall;
    logic                      w_boundary;
    logic [CNT_W-1:0]          w_cnt_next;
    logic                      w_mode_next;
    logic signed [15:0]        w_tx_left_next;
    logic signed [15:0]        w_tx_right_next;
    slot_pos_t                 w_tx_pos;
    slot_pos_t                 w_rx_pos;
    logic                      w_lrck_next;
    logic                      w_dac_next;

    assign w_run  = (r_state == RUN);
    assign o_bclk = w_bclk;

    wm8731_bclk_gen #(
        .BCLK_HALF (BCLK_HALF)
    ) u_bclk_gen (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_run      (w_run),
        .o_bclk     (w_bclk),
        .o_rise_evt (w_rise),
        .o_fall_evt (w_fall)
    );

    // Pin values are computed from the position, mode and samples that will be
    // in force after this fall, so the boundary cycle already uses the new frame.
    always_comb begin
        w_cnt_next      = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        w_boundary      = w_fall && (r_cnt == CNT_LAST);
        w_mode_next     = w_boundary ? i_mode : r_mode;
        w_tx_left_next  = w_boundary ? i_data_left : r_tx_left;
        w_tx_right_next = w_boundary ? i_data_right : r_tx_right;
        w_tx_pos        = slot_pos(int'(w_cnt_next), SLOT_BITS, w_mode_next);
        w_rx_pos        = slot_pos(int'(r_cnt), SLOT_BITS, r_mode);
        w_dac_next      = 1'b0;
        if (w_tx_pos.valid) begin
            w_dac_next = w_tx_pos.right ? w_tx_right_next[w_tx_pos.idx]
                                        : w_tx_left_next[w_tx_pos.idx];
        end
        if (w_mode_next == MODE_I2S) begin
            w_lrck_next = (int'(w_cnt_next) >= SLOT_BITS);
        end else begin
            w_lrck_next = (w_cnt_next == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_adc_meta <= 1'b0;
            r_adc_sync <= 1'b0;
        end else begin
            r_adc_meta <= i_adc_dat;
            r_adc_sync <= r_adc_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_cnt        <= CNT_LAST;
            r_mode       <= MODE_I2S;
            r_tx_left    <= '0;
            r_tx_right   <= '0;
            r_rx_left    <= '0;
            r_rx_right   <= '0;
            o_lrck       <= 1'b0;
            o_dac_dat    <= 1'b0;
            o_strobe     <= 1'b0;
            o_data_left  <= '0;
            o_data_right <= '0;
        end else begin
            o_strobe <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt     <= CNT_LAST;
                    o_lrck    <= 1'b0;
                    o_dac_dat <= 1'b0;
                    if (i_en) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_boundary && !i_en) begin
                        r_state   <= IDLE;
                        r_cnt     <= CNT_LAST;
                        o_lrck    <= 1'b0;
                        o_dac_dat <= 1'b0;
                    end else if (w_fall) begin
                        r_cnt     <= w_cnt_next;
                        o_lrck    <= w_lrck_next;
                        o_dac_dat <= w_dac_next;
                        if (w_boundary) begin
                            o_strobe     <= 1'b1;
                            r_mode       <= i_mode;
                            r_tx_left    <= i_data_left;
                            r_tx_right   <= i_data_right;
                            o_data_left  <= r_rx_left;
                            o_data_right <= r_rx_right;
                        end
                    end
                    if (w_rise && w_rx_pos.valid) begin
                        if (w_rx_pos.right) begin
                            r_rx_right[w_rx_pos.idx] <= r_adc_sync;
                        end else begin
                            r_rx_left[w_rx_pos.idx] <= r_adc_sync;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wm8731_master_if.sv
// Self-checking bench: DAC output looped back into ADC input, pins compared every
// cycle against a frame-timing reference model driven by elapsed clock count.
module tb_wm8731_master_if;

    localparam int H     = 8;
    localparam int S     = 32;
    localparam int FRAME = 2 * S;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               mode;
    logic signed [15:0] dl;
    logic signed [15:0] dr;
    logic               adc;
    logic               bclk;
    logic               lrck;
    logic               dac;
    logic               strobe;
    logic signed [15:0] ol;
    logic signed [15:0] orr;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_run = 0;
    bit          m_strobe = 0;
    bit          m_frame_active = 0;
    int          e = 0;
    logic        m_mode = 1'b1;
    logic [15:0] m_l = '0;
    logic [15:0] m_r = '0;
    logic [31:0] m_rx = '0;
    logic [31:0] m_odata = '0;

    // Stimulus control and timing measurements
    bit rand_data = 0;
    bit rand_mode = 0;
    int cyc = 0;
    int first_rise = -1;
    int first_strobe = -1;
    int second_strobe = -1;

    assign adc = dac;

    always #5 clk = ~clk;

    wm8731_master_if #(
        .BCLK_HALF (H),
        .SLOT_BITS (S)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_mode       (mode),
        .i_data_left  (dl),
        .i_data_right (dr),
        .i_adc_dat    (adc),
        .o_bclk       (bclk),
        .o_lrck       (lrck),
        .o_dac_dat    (dac),
        .o_strobe     (strobe),
        .o_data_left  (ol),
        .o_data_right (orr)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic ref_lrck(int p, logic md);
        if (md) return (p >= S);
        return (p == 0);
    endfunction

    function automatic logic ref_dac(int p, logic md, logic [15:0] l, logic [15:0] r);
        int k;
        if (md) begin
            k = p % S;
            if (k >= 1 && k <= 16) return (p < S) ? l[16-k] : r[16-k];
        end else begin
            if (p >= 1 && p <= 16) return l[16-p];
            if (p >= 17 && p <= 32) return r[32-p];
        end
        return 1'b0;
    endfunction

    function automatic bit is_boundary(int ev);
        return (ev >= 2 * H) && (ev % (2 * H) == 0) && (((ev / (2 * H)) - 1) % FRAME == 0);
    endfunction

    task automatic tick();
        logic [3:0] want_pins;
        logic       w_bclk;
        logic       w_lrck;
        logic       w_dac;
        int         p;
        @(posedge clk);
        m_strobe = 0;
        if (rst) begin
            m_run = 0; e = 0; m_frame_active = 0; m_rx = '0; m_odata = '0;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1; e = 0; cyc = -1;
                first_rise = -1; first_strobe = -1; second_strobe = -1;
            end
        end else begin
            e++;
            if (is_boundary(e)) begin
                if (m_frame_active) m_rx = {m_l, m_r};
                if (en) begin
                    m_strobe = 1; m_odata = m_rx; m_mode = mode;
                    m_l = dl; m_r = dr; m_frame_active = 1;
                end else begin
                    m_run = 0; m_frame_active = 0;
                end
            end
        end
        cyc++;
        @(negedge clk);
        w_bclk = m_run && ((e / H) % 2 == 1);
        w_lrck = 1'b0;
        w_dac  = 1'b0;
        if (m_run && e >= 2 * H) begin
            p = ((e / (2 * H)) - 1) % FRAME;
            w_lrck = ref_lrck(p, m_mode);
            w_dac  = ref_dac(p, m_mode, m_l, m_r);
        end
        want_pins = {w_bclk, w_lrck, w_dac, m_strobe};
        check_value("pins", 32'({bclk, lrck, dac, strobe}), 32'(want_pins));
        check_value("adc_data", {ol, orr}, m_odata);
        if (bclk && first_rise < 0) first_rise = cyc;
        if (strobe) begin
            if (first_strobe < 0) first_strobe = cyc;
            else if (second_strobe < 0) second_strobe = cyc;
        end
        if (rand_data) begin
            dl = 16'($urandom);
            dr = 16'($urandom);
        end
        if (rand_mode) mode = 1'($urandom);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_timing(input string tag);
        check_value({tag, "_first_rise"}, 32'(first_rise), 32'(H));
        check_value({tag, "_first_strobe"}, 32'(first_strobe), 32'(2 * H));
        check_value({tag, "_strobe_period"}, 32'(second_strobe - first_strobe), 32'(2 * H * FRAME));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b1; dl = '0; dr = '0;
        run_ticks(3);
        rst = 1'b0;
        run_ticks(2);

        // I2S with fixed pattern, then random samples, then loopback pattern
        dl = 16'hA5C3; dr = 16'h8001; en = 1'b1;
        run_ticks(2 * H * FRAME + 40);
        check_timing("i2s");
        rand_data = 1;
        run_ticks(2 * 2 * H * FRAME);
        rand_data = 0; dl = 16'h1234; dr = 16'hFEDC;
        run_ticks(2 * 2 * H * FRAME);

        // DSP mode A with the same samples, then random samples
        mode = 1'b0;
        run_ticks(2 * 2 * H * FRAME);
        rand_data = 1;
        run_ticks(2 * 2 * H * FRAME);

        // Mode randomised every cycle; then mode toggled and enable dropped mid-frame
        rand_mode = 1;
        run_ticks(2 * 2 * H * FRAME + 300);
        rand_mode = 0;
        mode = ~mode; en = 1'b0;
        run_ticks(2 * H * FRAME + 200);

        // Restart, then reset mid-frame and restart again
        en = 1'b1;
        run_ticks(2 * H * FRAME + 470);
        rst = 1'b1;
        run_ticks(1);
        rst = 1'b0;
        run_ticks(2 * H * FRAME + 40);
        check_timing("post_rst");
        run_ticks(2 * H * FRAME);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
